// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   VGA raster timing generator. A clock divider produces one pix_en pulse
//   every CLK_DIV clocks. The column and line counters advance on each pulse
//   and trace out an H_TOTAL x V_TOTAL raster. The decoded sync and
//   visible-area outputs are registered, so they never glitch.
//
// Ports
//   clk          system clock, single domain
//   rst          asynchronous, active-high reset
//   hCount[9:0]  current column, 0..H_TOTAL-1
//   vCount[9:0]  current line, 0..V_TOTAL-1
//   hSync        horizontal sync, active low while hCount < H_SYNC
//   vSync        vertical sync, active low while vCount < V_SYNC
//   bright       high while (hCount, vCount) lies inside the visible window
//   pix_en       one-clock pulse per pixel; the counters advance on it
//   frame_start  one-clock pulse on the first clock at (0,0) after a wrap
//   frame_cnt    frames completed since reset, modulo 256
//
// Build option
//   VGA_PIPE_ALIGN_EN  when defined, hSync/vSync/bright pass through one more
//                      register so they line up with one-cycle-latency
//                      sprite ROM data. Counters, pix_en and frame_start are
//                      not delayed.
module vga_timing_gen #(
  parameter int CLK_DIV     = 4,
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_VIS_START = 144,
  parameter int H_VIS_END   = 784,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_VIS_START = 35,
  parameter int V_VIS_END   = 515
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] hCount,
  output logic [9:0] vCount,
  output logic       hSync,
  output logic       vSync,
  output logic       bright,
  output logic       pix_en,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]       H_SYNC_W = 10'(H_SYNC);
  localparam logic [9:0]       V_SYNC_W = 10'(V_SYNC);
  localparam logic [9:0]       H_VIS_LO = 10'(H_VIS_START);
  localparam logic [9:0]       H_VIS_HI = 10'(H_VIS_END);
  localparam logic [9:0]       V_VIS_LO = 10'(V_VIS_START);
  localparam logic [9:0]       V_VIS_HI = 10'(V_VIS_END);

  // Sync is high (inactive) once the counter has left the sync pulse.
  function automatic logic sync_level(input logic [9:0] cnt,
                                      input logic [9:0] width);
    return cnt >= width;
  endfunction

  function automatic logic in_window(input logic [9:0] cnt,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

  logic [DIV_W-1:0] div_p0;
  logic             h_wrap;
  logic             v_wrap;
  logic [9:0]       h_next;
  logic [9:0]       v_next;
  logic             hsync_p0;
  logic             vsync_p0;
  logic             bright_p0;

  // Stage 0: pixel clock divider.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    div_p0 <= '0;
    else if (div_p0 == DIV_LAST) div_p0 <= '0;
    else                        div_p0 <= div_p0 + DIV_ONE;
  end

  // Gated by rst so that pix_en is held low during reset even when CLK_DIV is 1.
  assign pix_en = ~rst & (div_p0 == DIV_LAST);

  always_comb begin
    h_wrap = (hCount == H_LAST);
    v_wrap = (vCount == V_LAST);
    h_next = h_wrap ? 10'd0 : hCount + 10'd1;
    v_next = vCount;
    if (h_wrap) v_next = v_wrap ? 10'd0 : vCount + 10'd1;
  end

  // Stage 0: raster counters and decoded outputs. The decode uses the *next*
  // counter values, so the registered sync/bright always describe the
  // counters they are presented alongside.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hCount      <= '0;
      vCount      <= '0;
      hsync_p0    <= 1'b0;
      vsync_p0    <= 1'b0;
      bright_p0   <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        hCount    <= h_next;
        vCount    <= v_next;
        hsync_p0  <= sync_level(h_next, H_SYNC_W);
        vsync_p0  <= sync_level(v_next, V_SYNC_W);
        bright_p0 <= in_window(h_next, H_VIS_LO, H_VIS_HI) &&
                     in_window(v_next, V_VIS_LO, V_VIS_HI);
        if (h_wrap && v_wrap) begin
          frame_start <= 1'b1;
          frame_cnt   <= frame_cnt + 8'd1;
        end
      end
    end
  end

`ifdef VGA_PIPE_ALIGN_EN
  // Stage 1: alignment register for the sprite ROM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hSync  <= 1'b0;
      vSync  <= 1'b0;
      bright <= 1'b0;
    end else begin
      hSync  <= hsync_p0;
      vSync  <= vsync_p0;
      bright <= bright_p0;
    end
  end
`else
  assign hSync  = hsync_p0;
  assign vSync  = vsync_p0;
  assign bright = bright_p0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  // Small raster so full frames and a 256-frame wrap fit in a short run.
  localparam int D   = 2;
  localparam int HT  = 12;
  localparam int HS  = 2;
  localparam int HVS = 3;
  localparam int HVE = 10;
  localparam int VT  = 8;
  localparam int VS  = 1;
  localparam int VVS = 2;
  localparam int VVE = 7;
  localparam int FRAME_CLKS = D * HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] hCount, vCount;
  logic       hSync, vSync, bright, pix_en, frame_start;
  logic [7:0] frame_cnt;

  vga_timing_gen #(
    .CLK_DIV(D), .H_TOTAL(HT), .H_SYNC(HS), .H_VIS_START(HVS), .H_VIS_END(HVE),
    .V_TOTAL(VT), .V_SYNC(VS), .V_VIS_START(VVS), .V_VIS_END(VVE)
  ) dut (
    .clk(clk), .rst(rst), .hCount(hCount), .vCount(vCount), .hSync(hSync),
    .vSync(vSync), .bright(bright), .pix_en(pix_en), .frame_start(frame_start),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int t;          // clock edges seen since reset was released
  bit chk_en = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) t <= 0;
    else     t <= t + 1;
  end

  typedef struct {
    int h, v, fc;
    bit hs, vs, br, pe, fs;
  } exp_t;

  // Reference: the raster position is just elapsed pixels = edges / CLK_DIV.
  function automatic exp_t model(int tt);
    exp_t e;
    int p, q;
    bit have_q;
    p      = tt / D;
    e.h    = p % HT;
    e.v    = (p / HT) % VT;
    e.fc   = (p / (HT * VT)) % 256;
    e.pe   = (tt % D) == D - 1;
    e.fs   = (tt > 0) && (tt % FRAME_CLKS == 0);
`ifdef VGA_PIPE_ALIGN_EN
    have_q = tt > 0;
    q      = (tt > 0) ? (tt - 1) / D : 0;
`else
    have_q = 1'b1;
    q      = p;
`endif
    e.hs = have_q && ((q % HT) >= HS);
    e.vs = have_q && (((q / HT) % VT) >= VS);
    e.br = have_q && ((q % HT) >= HVS) && ((q % HT) < HVE) &&
           (((q / HT) % VT) >= VVS) && (((q / HT) % VT) < VVE);
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0d)", name, act, exp, t);
    end
  endtask

  function automatic longint pack_out();
    return {hCount, vCount, hSync, vSync, bright, pix_en, frame_start, frame_cnt};
  endfunction

  // Cycle-by-cycle comparison of every output against the reference.
  always @(negedge clk) begin : cont_chk
    exp_t   e;
    longint x;
    if (chk_en) begin
      if (rst) x = 0;
      else begin
        e = model(t);
        x = {10'(e.h), 10'(e.v), e.hs, e.vs, e.br, e.pe, e.fs, 8'(e.fc)};
      end
      n_chk++;
      if (pack_out() != x) begin
        n_fail++;
        $display("FAIL cycle_model: t=%0d got h=%0d v=%0d hs=%b vs=%b br=%b pe=%b fs=%b fc=%0d, expected packed %h got %h",
                 t, hCount, vCount, hSync, vSync, bright, pix_en, frame_start, frame_cnt, x, pack_out());
      end
    end
  end

  typedef struct {
    int t, h, v, fc;
    bit pe, fs;
  } vec_t;
  vec_t tbl[8];

  // Assert rst off the clock edge and confirm outputs clear before the next edge.
  task automatic async_reset(input int off, input int hold);
    @(negedge clk);
    #(off) rst = 1'b1;
    #(4 - off);
    check("async_rst_outputs_zero", pack_out(), 0);
    repeat (hold) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to(input int target, input int budget);
    int c;
    c = 0;
    while (t < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("run_to_reached", t, target);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n, br_cnt, hs_lo, vs_lo, fc0, cyc;
    bit found;
    tbl[0] = '{t:0,   h:0,  v:0, fc:0, pe:0, fs:0};
    tbl[1] = '{t:1,   h:0,  v:0, fc:0, pe:1, fs:0};
    tbl[2] = '{t:2,   h:1,  v:0, fc:0, pe:0, fs:0};
    tbl[3] = '{t:23,  h:11, v:0, fc:0, pe:1, fs:0};
    tbl[4] = '{t:24,  h:0,  v:1, fc:0, pe:0, fs:0};
    tbl[5] = '{t:191, h:11, v:7, fc:0, pe:1, fs:0};
    tbl[6] = '{t:192, h:0,  v:0, fc:1, pe:0, fs:1};
    tbl[7] = '{t:193, h:0,  v:0, fc:1, pe:1, fs:0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_hCount", hCount, 0);
    check("reset_vCount", vCount, 0);
    check("reset_syncs_bright", {hSync, vSync, bright}, 0);
    check("reset_pulses", {pix_en, frame_start}, 0);
    check("reset_frame_cnt", frame_cnt, 0);
    chk_en = 1'b1;
    rst = 1'b0;

    // Directed vectors from reset release
    for (int i = 0; i < 8; i++) begin
      run_to(tbl[i].t, 1000);
      check("vec_hCount", hCount, tbl[i].h);
      check("vec_vCount", vCount, tbl[i].v);
      check("vec_pix_en", pix_en, tbl[i].pe);
      check("vec_frame_start", frame_start, tbl[i].fs);
      check("vec_frame_cnt", frame_cnt, tbl[i].fc);
    end

    // One full frame: period, visible pixels and sync widths
    cyc = 0;
    while (!frame_start && cyc < 1000) begin @(negedge clk); cyc++; end
    check("frame_start_seen", frame_start, 1);
    fc0 = frame_cnt; n = 0; br_cnt = 0; hs_lo = 0; vs_lo = 0;
    do begin
      br_cnt += int'(bright);
      hs_lo  += int'(!hSync);
      vs_lo  += int'(!vSync);
      @(negedge clk);
      n++;
    end while (!frame_start && n < 1000);
    check("frame_period_clks", n, FRAME_CLKS);
    check("frame_bright_clks", br_cnt, (HVE - HVS) * (VVE - VVS) * D);
    check("frame_hsync_low_clks", hs_lo, HS * D * VT);
    check("frame_vsync_low_clks", vs_lo, VS * HT * D);
    check("frame_cnt_step", frame_cnt, (fc0 + 1) % 256);

    // Line wrap mid-frame: no frame_start
    cyc = 0; found = 0;
    while (!found && cyc < 1000) begin
      @(negedge clk); cyc++;
      found = (hCount == 10'(HT - 1)) && (vCount == 10'd3) && pix_en;
    end
    check("line_wrap_found", found, 1);
    @(negedge clk);
    check("line_wrap_hCount", hCount, 0);
    check("line_wrap_vCount", vCount, 4);
    check("line_wrap_no_frame_start", frame_start, 0);

    // Asynchronous reset mid-frame, then restart
    cyc = 0;
    while (!(hCount == 10'd6 && vCount == 10'd5) && cyc < 1000) begin @(negedge clk); cyc++; end
    check("mid_frame_pos_found", {hCount, vCount}, {10'd6, 10'd5});
    async_reset(2, 2);
    run_to(D, 100);
    check("restart_first_pix_en_hcount", hCount, 1);

    // Randomised run lengths and reset points
    for (int k = 0; k < 12; k++) begin
      repeat ($urandom_range(20, 1500)) @(negedge clk);
      async_reset($urandom_range(1, 3), $urandom_range(0, 3));
    end

    // 256 frames: frame_cnt wraps to 0
    run_to(255 * FRAME_CLKS, 60000);
    check("frame_cnt_255", frame_cnt, 255);
    check("frame_start_255", frame_start, 1);
    run_to(256 * FRAME_CLKS, 1000);
    check("frame_cnt_wrap", frame_cnt, 0);
    check("frame_start_wrap", frame_start, 1);
    repeat (3) @(negedge clk);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
